axi_read_arbiter: RTL and testbench
===================================

# axi_read_arbiter

Two-master to one-slave AXI3 read-channel arbiter that shares the CPU's single external AR/R port between the instruction-fetch requester (master 0) and the data requester (master 1). It grants one read transaction at a time in round-robin order, forwards the granted AR beat, and routes the R beats back to the owner. It counts beats against the granted arlen and flags length violations. It sits between the cache/uncached request FSMs and the top-level AXI read ports, and replaces the read half of the vendor crossbar.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, read data width
- ID_W, 4, AXI ID width
- LEN_W, 8, arlen width (AXI4-style field; AXI3 masters zero-extend 4-bit len)

- clk  in  1  clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- s_arid  in  2*ID_W  per-master ARID; [ID_W-1:0]=master 1, upper=master 0 (same packing for all s_* vectors)
- s_araddr  in  2*ADDR_W  per-master address
- s_arlen  in  2*LEN_W  per-master burst length minus one
- s_arsize  in  2*3  per-master beat size
- s_arburst  in  2*2  per-master burst type
- s_arvalid  in  2  per-master request
- s_arready  out  2  per-master address accept
- s_rdata  out  2*DATA_W  per-master read data (both copies driven from m_rdata)
- s_rresp  out  2*2  per-master response
- s_rlast  out  2  per-master last beat
- s_rvalid  out  2  per-master data valid
- s_rready  in  2  per-master data ready
- m_arid, m_araddr, m_arlen, m_arsize, m_arburst  out  ID_W/ADDR_W/LEN_W/3/2  slave-side AR fields
- m_arvalid  out  1  slave-side request
- m_arready  in  1  slave-side accept
- m_rid  in  ID_W  ignored for routing
- m_rdata  in  DATA_W; m_rresp  in  2; m_rlast  in  1; m_rvalid  in  1  slave-side R beat
- m_rready  out  1  slave-side data ready
- len_err  out  1  one-cycle pulse on beat-count/rlast mismatch
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, ADDR, DATA. Registers: grant (1 bit), prio (1 bit, the master favoured on a tie), beat_cnt (LEN_W bits), and a latched copy of the granted arlen.
- IDLE: if exactly one s_arvalid is high, grant that master. If both are high, grant prio. Register grant, go to ADDR. If none is high, stay.
- ADDR: m_ar* = granted master's s_ar* fields (combinational mux). m_arvalid=1. s_arready[grant]=m_arready; the other s_arready is 0. On m_arvalid&m_arready: latch arlen, clear beat_cnt, go to DATA.
- DATA: s_rvalid[grant]=m_rvalid and m_rready=s_rready[grant]. The non-granted s_rvalid is 0. s_rdata/s_rresp/s_rlast are broadcast to both masters. Each handshake increments beat_cnt (wraps modulo 2^LEN_W).
- Completion: on the handshake with m_rlast=1, go to IDLE and set prio = ~grant.
- len_err pulses for one cycle in either of two cases:
  - m_rlast=1 with beat_cnt ≠ latched arlen;
  - a handshake with beat_cnt == arlen and m_rlast=0. Continue forwarding beats until m_rlast arrives.
- Masters hold s_ar* stable while s_arvalid is high (AXI rule). The arbiter does not re-arbitrate in ADDR, even if the granted master drops s_arvalid. AXI forbids that, so the behaviour there is don't-care, but it must not deadlock.
- Only one transaction is outstanding at a time, so no ID remapping is done. m_arid = granted s_arid.

## Timing
- Reset (async assert, sync release): state=IDLE, grant=0, prio=0 (master 0 favoured), beat_cnt=0, arlen latch=0. m_arvalid=0, s_arready=0, s_rvalid=0, m_rready=0, len_err=0, busy=0. m_ar* mux outputs select master 0.
- s_arvalid sampled high at edge N → m_arvalid high during cycle N+1. Minimum AR latency is 1 cycle.
- Accept in cycle A → the first R beat can be forwarded in cycle A+1. R path is combinational, zero added latency.
- Last beat handshake in cycle L → IDLE in L+1; the next grant is registered at the end of L+1 and m_arvalid rises in L+2. Back-to-back turnaround is 2 bubble cycles.
- Reset asserted mid-ADDR or mid-DATA: all outputs return to reset values immediately. The in-flight transaction is abandoned, and the system resets the slave together with the arbiter.
- len_err is combinational from the handshake cycle. It is high only in that cycle.

## Test plan
- Single master-0 burst, arlen=3, slave returns 4 beats with rlast on the 4th: m_arvalid one cycle after s_arvalid; 4 beats on s_rvalid[0], none on [1]; busy drops the cycle after the last beat; len_err stays 0.
- Both masters request in the same cycle right after reset: master 0 is granted first (arlen=0, 1 beat). Master 1 is granted next, with its m_arvalid 2 cycles after master 0's rlast handshake. prio ends at 0.
- Master 1 holds s_rready=0 for 3 cycles while m_rvalid=1: m_rready stays 0 for those cycles and beat_cnt does not advance.
- Slave drives rlast on beat 2 of an arlen=3 burst: len_err pulses exactly on that beat and the arbiter returns to IDLE. A second case sends 5 beats with rlast on the 5th: len_err pulses on beat 4 and again on beat 5.
- resetn asserted during DATA beat 2: all outputs go to reset values in the same cycle. After release, a new master-1 request is granted normally.
- m_arready held low 5 cycles: m_arvalid and the m_ar* fields stay stable, and s_arready[grant] stays low until acceptance.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// Two-master to one-slave AXI3 read-channel arbiter: round-robin grant of one
// read transaction at a time, AR forwarding, R routing and beat-count checking.
module axi_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                resetn,
  // Per-master vectors: low slice = master 1, high slice = master 0.
  input  logic [2*ID_W-1:0]   s_arid,
  input  logic [2*ADDR_W-1:0] s_araddr,
  input  logic [2*LEN_W-1:0]  s_arlen,
  input  logic [5:0]          s_arsize,
  input  logic [3:0]          s_arburst,
  input  logic [1:0]          s_arvalid,
  output logic [1:0]          s_arready,
  output logic [2*DATA_W-1:0] s_rdata,
  output logic [3:0]          s_rresp,
  output logic [1:0]          s_rlast,
  output logic [1:0]          s_rvalid,
  input  logic [1:0]          s_rready,
  output logic [ID_W-1:0]     m_arid,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [LEN_W-1:0]    m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [ID_W-1:0]     m_rid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic                len_err,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              prio_q, prio_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0]  arlen_q, arlen_d;

  // Per-master views indexed by master number.
  logic [ID_W-1:0]   arid_m    [2];
  logic [ADDR_W-1:0] araddr_m  [2];
  logic [LEN_W-1:0]  arlen_m   [2];
  logic [2:0]        arsize_m  [2];
  logic [1:0]        arburst_m [2];
  logic [1:0]        req_m;
  logic              slot;
  logic              unused_rid;

  assign arid_m[0]    = s_arid[2*ID_W-1:ID_W];
  assign arid_m[1]    = s_arid[ID_W-1:0];
  assign araddr_m[0]  = s_araddr[2*ADDR_W-1:ADDR_W];
  assign araddr_m[1]  = s_araddr[ADDR_W-1:0];
  assign arlen_m[0]   = s_arlen[2*LEN_W-1:LEN_W];
  assign arlen_m[1]   = s_arlen[LEN_W-1:0];
  assign arsize_m[0]  = s_arsize[5:3];
  assign arsize_m[1]  = s_arsize[2:0];
  assign arburst_m[0] = s_arburst[3:2];
  assign arburst_m[1] = s_arburst[1:0];
  assign req_m        = {s_arvalid[0], s_arvalid[1]};

  // Bit position of the granted master inside the 2-bit per-master vectors.
  assign slot       = ~grant_q;
  assign unused_rid = ^m_rid;

  assign m_arid    = arid_m[grant_q];
  assign m_araddr  = araddr_m[grant_q];
  assign m_arlen   = arlen_m[grant_q];
  assign m_arsize  = arsize_m[grant_q];
  assign m_arburst = arburst_m[grant_q];

  assign s_rdata = {2{m_rdata}};
  assign s_rresp = {2{m_rresp}};
  assign s_rlast = {2{m_rlast}};
  assign busy    = (state_q != IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    grant_d    = grant_q;
    prio_d     = prio_q;
    beat_cnt_d = beat_cnt_q;
    arlen_d    = arlen_q;
    m_arvalid  = 1'b0;
    s_arready  = 2'b00;
    s_rvalid   = 2'b00;
    m_rready   = 1'b0;
    len_err    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_m[0] && req_m[1]) begin
          grant_d = prio_q;
          state_d = ADDR;
        end else if (req_m[0]) begin
          grant_d = 1'b0;
          state_d = ADDR;
        end else if (req_m[1]) begin
          grant_d = 1'b1;
          state_d = ADDR;
        end
      end

      ADDR: begin
        m_arvalid       = 1'b1;
        s_arready[slot] = m_arready;
        if (m_arready) begin
          arlen_d    = m_arlen;
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end

      DATA: begin
        s_rvalid[slot] = m_rvalid;
        m_rready       = s_rready[slot];
        if (m_rvalid && s_rready[slot]) begin
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
          // Early rlast, or the expected last beat arriving without rlast.
          if (m_rlast) begin
            len_err = (beat_cnt_q != arlen_q);
            state_d = IDLE;
            prio_d  = ~grant_q;
          end else begin
            len_err = (beat_cnt_q == arlen_q);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      prio_q     <= 1'b0;
      beat_cnt_q <= '0;
      arlen_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q    <= state_d;
      grant_q    <= grant_d;
      prio_q     <= prio_d;
      beat_cnt_q <= beat_cnt_d;
      arlen_q    <= arlen_d;
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed self-checking bench for axi_read_arbiter. Per-master vectors put
// master 0 in the high slice/bit and master 1 in the low slice/bit.
module tb_axi_read_arbiter;

  logic        clk;
  logic        resetn;
  logic [7:0]  s_arid;
  logic [63:0] s_araddr;
  logic [15:0] s_arlen;
  logic [5:0]  s_arsize;
  logic [3:0]  s_arburst;
  logic [1:0]  s_arvalid;
  logic [1:0]  s_arready;
  logic [63:0] s_rdata;
  logic [3:0]  s_rresp;
  logic [1:0]  s_rlast;
  logic [1:0]  s_rvalid;
  logic [1:0]  s_rready;
  logic [3:0]  m_arid;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid;
  logic        m_arready;
  logic [3:0]  m_rid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        m_rvalid;
  logic        m_rready;
  logic        len_err;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [3:0]  ID_M0   = 4'hA;
  localparam logic [3:0]  ID_M1   = 4'h5;
  localparam logic [31:0] ADDR_M0 = 32'h1000_0040;
  localparam logic [31:0] ADDR_M1 = 32'h2000_0080;

  axi_read_arbiter dut (
    .clk(clk), .resetn(resetn),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready), .len_err(len_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Inputs change 2 time units after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_arvalid"}, m_arvalid, 1'b0);
    check({tag, "_arready"}, s_arready, 2'b00);
    check({tag, "_rvalid"},  s_rvalid,  2'b00);
    check({tag, "_rready"},  m_rready,  1'b0);
    check({tag, "_len_err"}, len_err,   1'b0);
    check({tag, "_busy"},    busy,      1'b0);
    check({tag, "_arid"},    m_arid,    ID_M0);
  endtask

  task automatic do_reset(input string tag);
    resetn    = 1'b0;
    s_arvalid = 2'b00;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rlast   = 1'b0;
    #1;
    check_idle_outputs(tag);
    tick();
    resetn = 1'b1;
  endtask

  // Request from the given masters, then have the slave accept on the next cycle.
  task automatic grant_and_accept(input logic [1:0] req, input logic [1:0] exp_ready, input string tag);
    s_arvalid = req;
    tick();
    m_arready = 1'b1;
    #1;
    check({tag, "_arready"}, s_arready, exp_ready);
    tick();
    s_arvalid = 2'b00;
    m_arready = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last, input logic exp_err,
                      input logic [1:0] exp_rv, input string tag);
    m_rvalid = 1'b1;
    m_rdata  = d;
    m_rlast  = last;
    #1;
    check({tag, "_rvalid"},  s_rvalid, exp_rv);
    check({tag, "_len_err"}, len_err,  exp_err);
    check({tag, "_rdata"},   s_rdata,  {d, d});
    tick();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  initial begin
    s_arid    = {ID_M0, ID_M1};
    s_araddr  = {ADDR_M0, ADDR_M1};
    s_arlen   = 16'h0;
    s_arsize  = {3'd2, 3'd2};
    s_arburst = {2'b01, 2'b01};
    s_rready  = 2'b11;
    m_rid     = 4'h0;
    m_rdata   = 32'h0;
    m_rresp   = 2'b00;
    do_reset("reset");

    // Single master-0 burst of 4 beats.
    s_arlen   = {8'd3, 8'd0};
    s_arvalid = 2'b10;
    #1;
    check("t1_arvalid_pre", m_arvalid, 1'b0);
    tick();
    #1;
    check("t1_arvalid", m_arvalid, 1'b1);
    check("t1_araddr",  m_araddr,  ADDR_M0);
    check("t1_arlen",   m_arlen,   8'd3);
    check("t1_busy",    busy,      1'b1);
    check("t1_arready_wait", s_arready, 2'b00);
    m_arready = 1'b1;
    #1;
    check("t1_arready", s_arready, 2'b10);
    tick();
    s_arvalid = 2'b00;
    m_arready = 1'b0;
    for (int i = 0; i < 4; i++) beat(32'hA000 + 32'(i), i == 3, 1'b0, 2'b10, "t1_beat");
    #1;
    check("t1_busy_after", busy, 1'b0);

    // Simultaneous requests after reset: master 0 first, master 1 after 2 bubbles.
    do_reset("t2_reset");
    s_arlen   = {8'd0, 8'd0};
    s_arvalid = 2'b11;
    tick();
    #1;
    check("t2_first_id", m_arid, ID_M0);
    m_arready = 1'b1;
    tick();
    s_arvalid = 2'b01;
    m_arready = 1'b0;
    beat(32'h11, 1'b1, 1'b0, 2'b10, "t2_m0");
    #1;
    check("t2_bubble_arvalid", m_arvalid, 1'b0);
    check("t2_bubble_busy",    busy,      1'b0);
    tick();
    #1;
    check("t2_second_arvalid", m_arvalid, 1'b1);
    check("t2_second_id",      m_arid,    ID_M1);
    m_arready = 1'b1;
    #1;
    check("t2_second_arready", s_arready, 2'b01);
    tick();
    s_arvalid = 2'b00;
    m_arready = 1'b0;
    beat(32'h22, 1'b1, 1'b0, 2'b01, "t2_m1");
    // prio is back to master 0, so a tie now goes to master 0.
    s_arvalid = 2'b11;
    tick();
    #1;
    check("t2_prio_id", m_arid, ID_M0);
    m_arready = 1'b1;
    tick();
    s_arvalid = 2'b00;
    m_arready = 1'b0;
    beat(32'h33, 1'b1, 1'b0, 2'b10, "t2_m0b");

    // Master 1 stalls R for 3 cycles; beat count must not advance.
    s_arlen = {8'd0, 8'd1};
    grant_and_accept(2'b01, 2'b01, "t3");
    s_rready = 2'b10;
    m_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_stall_rready", m_rready, 1'b0);
      check("t3_stall_rvalid", s_rvalid, 2'b01);
      tick();
    end
    s_rready = 2'b11;
    beat(32'h44, 1'b0, 1'b0, 2'b01, "t3_b0");
    beat(32'h45, 1'b1, 1'b0, 2'b01, "t3_b1");

    // Early rlast on beat 2 of an arlen=3 burst.
    s_arlen = {8'd3, 8'd0};
    grant_and_accept(2'b10, 2'b10, "t4a");
    beat(32'h50, 1'b0, 1'b0, 2'b10, "t4a_b0");
    beat(32'h51, 1'b1, 1'b1, 2'b10, "t4a_b1");
    #1;
    check("t4a_busy",    busy,    1'b0);
    check("t4a_err_off", len_err, 1'b0);

    // Five beats for arlen=3: error on beat 4 and on beat 5.
    grant_and_accept(2'b10, 2'b10, "t4b");
    for (int i = 0; i < 5; i++) beat(32'h60 + 32'(i), i == 4, i >= 3, 2'b10, "t4b_beat");
    #1;
    check("t4b_busy", busy, 1'b0);

    // Reset asserted during beat 2 of a master-1 burst.
    s_arlen = {8'd0, 8'd3};
    grant_and_accept(2'b01, 2'b01, "t5");
    beat(32'h70, 1'b0, 1'b0, 2'b01, "t5_b0");
    m_rvalid = 1'b1;
    m_rdata  = 32'h71;
    #1;
    check("t5_pre_rvalid", s_rvalid, 2'b01);
    resetn = 1'b0;
    #1;
    check_idle_outputs("t5_mid");
    m_rvalid = 1'b0;
    tick();
    resetn  = 1'b1;
    s_arlen = {8'd0, 8'd0};
    s_arvalid = 2'b01;
    tick();
    #1;
    check("t5_regrant_arvalid", m_arvalid, 1'b1);
    check("t5_regrant_id",      m_arid,    ID_M1);
    m_arready = 1'b1;
    tick();
    s_arvalid = 2'b00;
    m_arready = 1'b0;
    beat(32'h72, 1'b1, 1'b0, 2'b01, "t5_after");

    // Slave holds m_arready low for 5 cycles.
    s_arlen   = {8'd2, 8'd0};
    s_arvalid = 2'b10;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t6_arvalid", m_arvalid, 1'b1);
      check("t6_araddr",  m_araddr,  ADDR_M0);
      check("t6_arlen",   m_arlen,   8'd2);
      check("t6_arready", s_arready, 2'b00);
      tick();
    end
    m_arready = 1'b1;
    #1;
    check("t6_accept", s_arready, 2'b10);
    tick();
    s_arvalid = 2'b00;
    m_arready = 1'b0;
    for (int i = 0; i < 3; i++) beat(32'h80 + 32'(i), i == 2, 1'b0, 2'b10, "t6_beat");
    #1;
    check("t6_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
